// File: rtl/spr_ram_arbiter_if.sv
// spr_ram_arbiter_if: bundles both requester ports, the RAM access pins and
// the conflict counter of the SPI RAM arbiter.
// Handshake: a requester holds req/we/addr/wdata stable until it sees a
// one-cycle ack; read data arrives later with a one-cycle rvalid strobe.
// slave = arbiter side, master = requesters/RAM side.
interface spr_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [7:0]            conflict_cnt;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output a_ack, a_rdata, a_rvalid,
    output b_ack, b_rdata, b_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output conflict_cnt
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  a_ack, a_rdata, a_rvalid,
    input  b_ack, b_rdata, b_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/spr_ram_arbiter.sv
// spr_ram_arbiter: grants port A (SPI) or port B (host) access to a
// single-port RAM, sequences the registered RAM pins and returns read data.
// Optional feature: define RAM_ARB_RR_EN for round-robin tie breaking;
// otherwise port A always wins ties.
module spr_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  spr_ram_arbiter_if.slave bus,
  output logic [1:0]       dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  grant;      // a grant is issued this IDLE cycle
  logic                  grant_b;    // the grant goes to port B
  logic                  cnt_inc;    // a requester is being denied this cycle
  logic                  win_b_q;    // winner of the access in flight
  logic                  a_ack_q, b_ack_q;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  ram_en_q, ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [7:0]            cnt_q;
`ifdef RAM_ARB_RR_EN
  logic                  last_b_q;   // last grant went to B
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration decision and denial detection
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          if (bus.a_req && bus.b_req) begin
            cnt_inc = 1'b1;
`ifdef RAM_ARB_RR_EN
            grant_b = ~last_b_q;
`else
            grant_b = 1'b0;
`endif
          end else begin
            grant_b = bus.b_req;
          end
        end
      end
      ACCESS: begin
        // ram_we_q still holds the winner's direction during ACCESS
        state_d = ram_we_q ? IDLE : RWAIT;
        cnt_inc = win_b_q ? bus.a_req : bus.b_req;
      end
      RWAIT: begin
        state_d = IDLE;
        cnt_inc = win_b_q ? bus.a_req : bus.b_req;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered RAM pins, acks, read-data return and conflict counter
  always_ff @(posedge clk) begin
    if (rst) begin
      win_b_q     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cnt_q       <= 8'd0;
    end else begin
      a_ack_q  <= grant & ~grant_b;
      b_ack_q  <= grant & grant_b;
      ram_en_q <= grant;
      ram_we_q <= grant & (grant_b ? bus.b_we : bus.a_we);
      if (grant) begin
        win_b_q     <= grant_b;
        ram_addr_q  <= grant_b ? bus.b_addr : bus.a_addr;
        ram_wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
      end
      a_rvalid_q <= (state_q == RWAIT) & ~win_b_q;
      b_rvalid_q <= (state_q == RWAIT) & win_b_q;
      if (state_q == RWAIT && !win_b_q) a_rdata_q <= bus.ram_rdata;
      if (state_q == RWAIT && win_b_q)  b_rdata_q <= bus.ram_rdata;
      if (cnt_inc && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Remember who was served last; reset favours A on the first tie
  always_ff @(posedge clk) begin
    if (rst)        last_b_q <= 1'b1;
    else if (grant) last_b_q <= grant_b;
  end
`endif

  assign bus.a_ack        = a_ack_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.a_rvalid     = a_rvalid_q;
  assign bus.b_rvalid     = b_rvalid_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.ram_en       = ram_en_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.conflict_cnt = cnt_q;
  assign dbg_state_o      = state_q;
endmodule
